bridge_rshift_pingpong: RTL
===========================

Name: bridge_rshift_pingpong

Overview:
- Parametrised successor bridge between the linear-projection outputs (Q/K/V tiles) and the self-attention head input.
- Collects NUM_SLOTS projection words into one of two ping-pong banks.
- Replays each full bank as a sequence of slot-rotated (right-shifted) output beats.
- Every element is scaled by a runtime arithmetic right shift (requantisation) on the way out.
- Adds valid/ready backpressure, double buffering, variable rotation count and early-terminated (partial) tiles.

Parameters:
- ELEM_WIDTH, 16, signed fixed-point element width.
- ELEMS_PER_WORD, 8, elements per projection word; WORD_W = ELEM_WIDTH*ELEMS_PER_WORD.
- NUM_SLOTS, 4, words per tile (head input width); power of two not required, must be >= 2.
- SHIFT_W, 5, width of cfg_shift; legal shift 0..ELEM_WIDTH-1.
- ROT_W, $clog2(NUM_SLOTS+1), width of cfg_rotations.

Ports:
- clk  in  1  single clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word valid.
- in_ready  out  1  bridge can accept a word.
- in_data  in  WORD_W  projection word.
- in_last  in  1  final word of a tile (may arrive before NUM_SLOTS words).
- cfg_shift  in  SHIFT_W  arithmetic right-shift amount, sampled per tile.
- cfg_rotations  in  ROT_W  output beats per tile, sampled per tile.
- out_valid  out  1  output beat valid.
- out_ready  in  1  consumer accepts beat.
- out_data  out  NUM_SLOTS*WORD_W  rotated, shifted tile; slot j at bits [j*WORD_W +: WORD_W].
- out_rot_idx  out  ROT_W  rotation index k of the current beat.
- out_last  out  1  final beat of the tile.

Behaviour:
- Reset: in_ready=0, out_valid=0, out_data=0, out_rot_idx=0, out_last=0, both banks EMPTY, write pointer 0. in_ready rises the first cycle after reset release.
- Bank states: EMPTY -> FILLING -> FULL -> DRAINING -> EMPTY. Write bank and read bank toggle independently.
- Input transfer when in_valid && in_ready: word stored at the write slot, write slot increments.
- Tile closes when the write slot reaches NUM_SLOTS-1 or in_last=1. Unfilled slots are zeroed.
- On tile close: cfg_shift and cfg_rotations are latched into the bank, the bank goes FULL, and writing switches to the other bank.
- in_ready=0 while the target write bank is not EMPTY. Both banks full stalls input.
- Rotation count R: cfg_rotations=0 is treated as 1; values above NUM_SLOTS clamp to NUM_SLOTS.
- Output beat k (0..R-1): out slot j = stored slot (j-k) mod NUM_SLOTS, i.e. right rotation by k.
- Each element output = stored element >>> shift (arithmetic, sign-preserving).
- out_rot_idx=k on every beat; out_last=1 on beat R-1.
- Output registers are held stable while out_valid && !out_ready.
- Latency: first out_valid is asserted 1 cycle after the closing input word is accepted, provided the read side is idle.
- Beats are back-to-back when out_ready=1. The next bank's beat 0 follows the previous bank's beat R-1 with no bubble.
- A bank returns to EMPTY in the cycle its last beat is accepted. in_ready may rise in that same cycle; there is no combinational path from out_ready to in_ready beyond that bank-free signal.
- Simultaneous close of the write bank and drain completion of the read bank are both honoured in the same cycle.
- Reset asserted mid-tile discards all banks immediately and returns outputs to reset values.

Optional Feature:
- Macro: BRIDGE_RSHIFT_ROUND_EN.
- Defined: round-half-up before the shift, i.e. add 1<<(shift-1) when shift>0. The result saturates to the signed ELEM_WIDTH range, so +32767 with shift 1 gives 16384 rather than wrapping.
- Undefined: plain truncating arithmetic shift with no saturation logic.

Decomposition:
- bridge_rshift_pkg holds:
  - WORD_W and ROT_W localparams;
  - bank_state_t enum {BANK_EMPTY, BANK_FILLING, BANK_FULL, BANK_DRAINING};
  - typedef for a tile (NUM_SLOTS words);
  - function clamp_rotations().
- One natural sub-module: bridge_elem_shifter, the combinational per-element arithmetic shift / rounding / saturation stage, instantiated ELEMS_PER_WORD*NUM_SLOTS times.

Test Plan:
- Full tile, shift 0, rotations 4. Words W0..W3 with element value 0x0100*(slot+1), out_ready=1. Expect 4 beats:
  - beat0 slots = W0,W1,W2,W3;
  - beat1 = W3,W0,W1,W2;
  - out_last only on beat 3;
  - first out_valid 1 cycle after W3 is accepted.
- Arithmetic shift: elements -256 and +255 with shift 4 give -16 and +15 (truncate). With BRIDGE_RSHIFT_ROUND_EN, +255 gives +16 and -256 gives -16.
- Partial tile: in_last on the 2nd word, rotations 2. Expect slots 2 and 3 zero; beat1 = 0,W0,W1,0.
- Backpressure and ping-pong:
  - out_ready held 0 while 3 tiles are offered: first two tiles accepted, then in_ready=0;
  - out_data is stable throughout the stall;
  - releasing out_ready drains tile A then tile B with no bubble between them.
- Rotation clamp: cfg_rotations=0 gives 1 beat with out_last=1; cfg_rotations=7 with NUM_SLOTS=4 gives 4 beats.
- Reset mid-drain: rst_n low during beat 1 forces out_valid=0 immediately. After release, a fresh tile's beat0 shows only new data.

Source files
------------

// File: rtl/bridge_rshift_pkg.sv
// Shared types and helpers for the rotating/requantising ping-pong bridge.
package bridge_rshift_pkg;

  localparam int ELEM_WIDTH_DEF     = 16;
  localparam int ELEMS_PER_WORD_DEF = 8;
  localparam int NUM_SLOTS_DEF      = 4;
  localparam int WORD_W             = ELEM_WIDTH_DEF * ELEMS_PER_WORD_DEF;
  localparam int ROT_W              = $clog2(NUM_SLOTS_DEF + 1);

  typedef enum logic [1:0] {
    BANK_EMPTY,
    BANK_FILLING,
    BANK_FULL,
    BANK_DRAINING
  } bank_state_t;

  typedef logic [NUM_SLOTS_DEF-1:0][WORD_W-1:0] tile_t;

  // Zero beats make no sense for a tile; more than one full turn repeats data.
  function automatic int clamp_rotations(input int rot, input int slots);
    if (rot == 0) return 1;
    if (rot > slots) return slots;
    return rot;
  endfunction

endpackage

// File: rtl/bridge_elem_shifter.sv
// Per-element arithmetic right shift; BRIDGE_RSHIFT_ROUND_EN adds
// round-half-up with saturation to the signed element range.
module bridge_elem_shifter #(
  parameter int ELEM_WIDTH = 16,
  parameter int SHIFT_W    = 5
) (
  input  logic [ELEM_WIDTH-1:0] elem,
  input  logic [SHIFT_W-1:0]    shift,
  output logic [ELEM_WIDTH-1:0] result
);

`ifdef BRIDGE_RSHIFT_ROUND_EN
  logic signed [ELEM_WIDTH:0] bias, wide, shifted;

  always_comb begin
    bias = '0;
    if (shift != '0) bias = {{ELEM_WIDTH{1'b0}}, 1'b1} << (shift - SHIFT_W'(1));
    wide    = {elem[ELEM_WIDTH-1], elem} + bias;
    shifted = wide >>> shift;
    // Extra headroom bit disagrees with the sign bit only on overflow.
    if (shifted[ELEM_WIDTH] != shifted[ELEM_WIDTH-1])
      result = shifted[ELEM_WIDTH] ? {1'b1, {(ELEM_WIDTH-1){1'b0}}}
                                   : {1'b0, {(ELEM_WIDTH-1){1'b1}}};
    else
      result = shifted[ELEM_WIDTH-1:0];
  end
`else
  assign result = $signed(elem) >>> shift;
`endif

endmodule

// File: rtl/bridge_rshift_pingpong.sv
// Ping-pong tile bridge: collects projection words into two banks and replays
// each full bank as right-rotated, right-shifted beats (BRIDGE_RSHIFT_ROUND_EN
// selects rounding/saturating requantisation in the element shifter).
module bridge_rshift_pingpong #(
  parameter int ELEM_WIDTH     = bridge_rshift_pkg::ELEM_WIDTH_DEF,
  parameter int ELEMS_PER_WORD = bridge_rshift_pkg::ELEMS_PER_WORD_DEF,
  parameter int NUM_SLOTS      = bridge_rshift_pkg::NUM_SLOTS_DEF,
  parameter int SHIFT_W        = 5,
  parameter int ROT_W          = $clog2(NUM_SLOTS + 1)
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [ELEM_WIDTH*ELEMS_PER_WORD-1:0]          in_data,
  input  logic                                          in_last,
  input  logic [SHIFT_W-1:0]                            cfg_shift,
  input  logic [ROT_W-1:0]                              cfg_rotations,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [NUM_SLOTS*ELEM_WIDTH*ELEMS_PER_WORD-1:0] out_data,
  output logic [ROT_W-1:0]                              out_rot_idx,
  output logic                                          out_last
);
  import bridge_rshift_pkg::*;

  localparam int WW     = ELEM_WIDTH * ELEMS_PER_WORD;
  localparam int SLOT_W = $clog2(NUM_SLOTS);

  logic [NUM_SLOTS-1:0][WW-1:0] bank_data [2];
  logic [SHIFT_W-1:0]           bank_shift [2];
  logic [ROT_W-1:0]             bank_rot [2];
  bank_state_t                  st [2], st_nxt [2];

  logic              wb, rb, wb_nxt, in_ready_q;
  logic [SLOT_W-1:0] ws;
  logic [ROT_W-1:0]  k;
  logic              in_fire, tile_close, out_fire, beat_last;
  logic [NUM_SLOTS-1:0][WW-1:0] shifted;

  assign in_ready   = in_ready_q;
  assign in_fire    = in_valid && in_ready_q;
  assign tile_close = in_fire && (in_last || ws == SLOT_W'(NUM_SLOTS - 1));
  assign wb_nxt     = tile_close ? ~wb : wb;
  assign out_valid  = (st[rb] == BANK_FULL) || (st[rb] == BANK_DRAINING);
  assign out_fire   = out_valid && out_ready;
  assign beat_last  = (k == bank_rot[rb] - ROT_W'(1));

  // Write and read sides never target the same bank in the same cycle:
  // writes need EMPTY/FILLING, reads need FULL/DRAINING.
  always_comb begin
    st_nxt = st;
    if (in_fire)  st_nxt[wb] = tile_close ? BANK_FULL : BANK_FILLING;
    if (out_fire) st_nxt[rb] = beat_last ? BANK_EMPTY : BANK_DRAINING;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st         <= '{BANK_EMPTY, BANK_EMPTY};
      bank_data  <= '{'0, '0};
      bank_shift <= '{'0, '0};
      bank_rot   <= '{'0, '0};
      wb         <= 1'b0;
      rb         <= 1'b0;
      ws         <= '0;
      k          <= '0;
      in_ready_q <= 1'b0;
    end else begin
      st         <= st_nxt;
      in_ready_q <= (st_nxt[wb_nxt] == BANK_EMPTY) || (st_nxt[wb_nxt] == BANK_FILLING);
      if (in_fire) begin
        bank_data[wb][ws] <= in_data;
        ws <= tile_close ? '0 : ws + SLOT_W'(1);
        if (tile_close) begin
          for (int j = 0; j < NUM_SLOTS; j++)
            if (j > int'(ws)) bank_data[wb][j] <= '0;
          bank_shift[wb] <= cfg_shift;
          bank_rot[wb]   <= ROT_W'(clamp_rotations(int'(cfg_rotations), NUM_SLOTS));
          wb             <= ~wb;
        end
      end
      if (out_fire) begin
        if (beat_last) begin
          k  <= '0;
          rb <= ~rb;
        end else begin
          k <= k + ROT_W'(1);
        end
      end
    end
  end

  // Output slot j shows stored slot (j - k) mod NUM_SLOTS.
  for (genvar j = 0; j < NUM_SLOTS; j++) begin : g_slot
    int            src;
    logic [WW-1:0] word;

    always_comb begin
      src = j - int'(k);
      if (src < 0) src = src + NUM_SLOTS;
      word = bank_data[rb][src[SLOT_W-1:0]];
    end

    bridge_elem_shifter #(
      .ELEM_WIDTH (ELEM_WIDTH),
      .SHIFT_W    (SHIFT_W)
    ) u_sh [ELEMS_PER_WORD-1:0] (
      .elem   (word),
      .shift  (bank_shift[rb]),
      .result (shifted[j])
    );
  end

  assign out_data    = out_valid ? shifted : '0;
  assign out_rot_idx = k;
  assign out_last    = out_valid && beat_last;

endmodule
